dm_access: RTL and testbench

DM_ACCESS -- requirements
Module: dm_access

---
 rtl/dm_pkg.sv | 37 +++
 rtl/dm_align.sv | 45 ++++
 rtl/dm_access.sv | 104 ++++++++++
 tb/tb_dm_access.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access unit: DMType encodings, FSM states,
// and the request-reject decode. Optional alignment checking is enabled by DM_MISALIGN_CHK_EN.
package dm_pkg;

  localparam logic [2:0] DM_WORD = 3'b100;
  localparam logic [2:0] DM_HALF = 3'b010;
  localparam logic [2:0] DM_BYTE = 3'b001;

`ifdef DM_MISALIGN_CHK_EN
  localparam bit MISALIGN_CHK = 1'b1;
`else
  localparam bit MISALIGN_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  dmtype;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Non-one-hot size codes are always rejected; misalignment only when checking is built in.
  function automatic logic dm_reject(input logic [2:0] dmtype, input logic [1:0] addr_lo);
    logic misaligned;
    misaligned = (dmtype == DM_HALF && addr_lo[0]) || (dmtype == DM_WORD && addr_lo != 2'b00);
    return !(dmtype inside {DM_WORD, DM_HALF, DM_BYTE}) || (MISALIGN_CHK && misaligned);
  endfunction

endpackage

// File: rtl/dm_align.sv
// Combinational lane steering: byte enables, store-data replication and
// load lane extraction with sign/zero extension.
module dm_align
  import dm_pkg::*;
(
  input  logic [2:0]  dmtype,
  input  logic [1:0]  addr_lo,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = '0;
    lane8     = rdata[{addr_lo, 3'b000} +: 8];
    lane16    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (dmtype)
      DM_WORD: begin
        be        = 4'b1111;
        rdata_ext = rdata;
      end
      DM_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{lane16[15] & ~uns}}, lane16};
      end
      DM_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{lane8[7] & ~uns}}, lane8};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_access.sv
// Load/store unit bridging a core request to a word-wide req/gnt/rvalid memory port.
// Build with DM_MISALIGN_CHK_EN to reject misaligned half/word accesses.
module dm_access
  import dm_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_dmtype,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  state_t      state;
  req_t        rq;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_ext;

  dm_align u_align (
    .dmtype    (rq.dmtype),
    .addr_lo   (rq.addr[1:0]),
    .uns       (rq.uns),
    .wdata     (rq.wdata),
    .rdata     (mem_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  // Memory-side outputs decode straight from registered state, so they hold steady through REQ.
  assign req_ready = (state == ST_IDLE);
  assign mem_req   = (state == ST_REQ);
  assign mem_we    = rq.we;
  assign mem_be    = be;
  assign mem_addr  = {rq.addr[31:2], 2'b00};
  assign mem_wdata = wdata_rep;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      rq         <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            rq <= '{we: req_we, dmtype: req_dmtype, uns: req_unsigned,
                    addr: req_addr, wdata: req_wdata};
            if (dm_reject(req_dmtype, req_addr[1:0])) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            if (rq.we) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= '0;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= rdata_ext;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access.sv
// Directed, table-driven bench for dm_access plus hand-written reset and
// late-rvalid sequences. Expectations follow DM_MISALIGN_CHK_EN when defined.
module tb_dm_access;

  logic        clk;
  logic        rstn;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [2:0]  req_dmtype;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dm_access dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_dmtype   (req_dmtype),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_req      (mem_req),
    .mem_gnt      (mem_gnt),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  dmtype;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gd;     // cycles mem_gnt is held low
    int          rd;     // cycles between grant and mem_rvalid
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] exp_rdata;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  task automatic run_vec(input vec_t v);
    int unsigned t0;
    int          lat, exp_lat;
    exp_lat = v.err ? 1 : (v.we ? 2 + v.gd : 3 + v.gd + v.rd);
    @(negedge clk);
    check({v.name, "_ready"}, req_ready, 1);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_dmtype   = v.dmtype;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    @(posedge clk);
    #1;
    t0 = cycle;
    req_valid  = 1'b0;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'h5A5A_5A5A;
    req_dmtype = 3'b111;
    if (!v.err) begin
      for (int i = 0; i <= v.gd; i++) begin
        @(negedge clk);
        check({v.name, "_mem_req"}, mem_req, 1);
        check({v.name, "_mem_addr"}, mem_addr, v.maddr);
        check({v.name, "_mem_be"}, mem_be, v.be);
        if (i == v.gd) mem_gnt = 1'b1;
      end
      check({v.name, "_mem_we"}, mem_we, v.we);
      if (v.we) check({v.name, "_mem_wdata"}, mem_wdata, v.mwdata);
      @(posedge clk);
      #1 mem_gnt = 1'b0;
      if (!v.we) begin
        for (int i = 0; i <= v.rd; i++) begin
          @(negedge clk);
          if (i == v.rd) begin
            mem_rvalid = 1'b1;
            mem_rdata  = v.rdata;
          end
        end
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hDEAD_BEEF;
      end
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) break;
    end
    lat = int'(cycle - t0) + 1;
    check({v.name, "_resp_valid"}, resp_valid, 1);
    check({v.name, "_latency"}, lat, exp_lat);
    check({v.name, "_resp_rdata"}, resp_rdata, v.exp_rdata);
    check({v.name, "_resp_err"}, resp_err, v.err);
    check({v.name, "_no_mem_req_in_resp"}, mem_req, 0);
    @(negedge clk);
    check({v.name, "_pulse_end"}, resp_valid, 0);
    check({v.name, "_ready_after"}, req_ready, 1);
  endtask

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_dmtype = 3'b000;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    //          name        we dmt     uns addr          wdata         rdata         gd rd be       maddr         mwdata        exp_rdata     err
    tbl.push_back('{"st_b103", 1, 3'b001, 0, 32'h0000_0103, 32'h0000_00AB, 32'h0,        0, 0, 4'b1000, 32'h0000_0100, 32'hABAB_ABAB, 32'h0,        0});
    tbl.push_back('{"ld_h202", 0, 3'b010, 0, 32'h0000_0202, 32'h0,        32'h8001_1234, 0, 3, 4'b1100, 32'h0000_0200, 32'h0,        32'hFFFF_8001, 0});
    tbl.push_back('{"ld_bu1",  0, 3'b001, 1, 32'h0000_0001, 32'h0,        32'h0000_F500, 4, 0, 4'b0010, 32'h0000_0000, 32'h0,        32'h0000_00F5, 0});
`ifdef DM_MISALIGN_CHK_EN
    tbl.push_back('{"ld_w2",   0, 3'b100, 0, 32'h0000_0002, 32'h0,        32'h1234_5678, 0, 0, 4'b1111, 32'h0,        32'h0,        32'h0,        1});
    tbl.push_back('{"st_h11",  1, 3'b010, 0, 32'h0000_0011, 32'h0000_1357, 32'h0,        0, 0, 4'b0011, 32'h0,        32'h0,        32'h0,        1});
`else
    tbl.push_back('{"ld_w2",   0, 3'b100, 0, 32'h0000_0002, 32'h0,        32'h1234_5678, 0, 0, 4'b1111, 32'h0000_0000, 32'h0,        32'h1234_5678, 0});
    tbl.push_back('{"st_h11",  1, 3'b010, 0, 32'h0000_0011, 32'h0000_1357, 32'h0,        0, 0, 4'b0011, 32'h0000_0010, 32'h1357_1357, 32'h0,        0});
`endif
    tbl.push_back('{"bad_011", 0, 3'b011, 0, 32'h0000_0040, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        1});
    tbl.push_back('{"bad_000", 1, 3'b000, 0, 32'h0000_0044, 32'h1111_1111, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        1});
    tbl.push_back('{"st_h2",   1, 3'b010, 0, 32'h0000_0002, 32'hFFFF_BEEF, 32'h0,        1, 0, 4'b1100, 32'h0000_0000, 32'hBEEF_BEEF, 32'h0,        0});
    tbl.push_back('{"st_w40",  1, 3'b100, 0, 32'h0000_0040, 32'hCAFE_F00D, 32'h0,        2, 0, 4'b1111, 32'h0000_0040, 32'hCAFE_F00D, 32'h0,        0});
    tbl.push_back('{"ld_bs3",  0, 3'b001, 0, 32'h0000_0083, 32'h0,        32'h8000_0000, 0, 1, 4'b1000, 32'h0000_0080, 32'h0,        32'hFFFF_FF80, 0});
    tbl.push_back('{"ld_hu0",  0, 3'b010, 1, 32'h0000_0010, 32'h0,        32'h1234_8765, 1, 1, 4'b0011, 32'h0000_0010, 32'h0,        32'h0000_8765, 0});
    tbl.push_back('{"ld_w8",   0, 3'b100, 0, 32'h0000_0008, 32'h0,        32'h89AB_CDEF, 0, 0, 4'b1111, 32'h0000_0008, 32'h0,        32'h89AB_CDEF, 0});
    tbl.push_back('{"ld_bs0",  0, 3'b001, 0, 32'h0000_0004, 32'h0,        32'hFFFF_FF7F, 0, 0, 4'b0001, 32'h0000_0004, 32'h0,        32'h0000_007F, 0});

    // Reset state while rstn is held low.
    #12;
    check("rst_req_ready", req_ready, 1);
    check("rst_mem_req", mem_req, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rstn = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset asserted mid-cycle while in REQ must clear outputs immediately.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_dmtype = 3'b100; req_unsigned = 1'b0;
    req_addr = 32'h0000_0F04; req_wdata = 32'h7654_3210;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("async_pre_mem_req", mem_req, 1);
    #2 rstn = 1'b0;
    #1;
    check("async_mem_req", mem_req, 0);
    check("async_req_ready", req_ready, 1);
    check("async_mem_addr", mem_addr, 0);
    check("async_mem_wdata", mem_wdata, 0);
    check("async_mem_be", mem_be, 0);
    check("async_mem_we", mem_we, 0);
    check("async_resp_rdata", resp_rdata, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Reset pulsed in WAIT, then a late rvalid: nothing may come back.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_dmtype = 3'b100; req_addr = 32'h0000_0020;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(posedge clk);
    #1 mem_gnt = 1'b0;
    @(negedge clk);
    check("wait_mem_req_low", mem_req, 0);
    check("wait_not_ready", req_ready, 0);
    rstn = 1'b0;
    #2;
    check("wait_rst_ready", req_ready, 1);
    @(negedge clk);
    rstn = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA5A5_A5A5;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("late_rvalid_no_resp", resp_valid, 0);
      check("late_rvalid_ready", req_ready, 1);
    end
    check("late_rvalid_rdata", resp_rdata, 0);

    // Unit recovers normally afterwards.
    run_vec(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=finish", cycle);
    $fatal(1, "timeout");
  end

endmodule
